// File: rtl/sr_driver.sv
// Pulse driver for an external SR flip-flop: issues s/r pulses toward a target value,
// waits for the output to settle, verifies q_fb and retries up to MAX_TRIES times.
module sr_driver #(
   parameter int SETTLE_CYCLES = 2,
   parameter int MAX_TRIES     = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic req_valid,
   input  logic req_bit,
   output logic req_ready,
   input  logic q_fb,
   output logic s,
   output logic r,
   output logic done,
   output logic err,
   output logic busy
);

   typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
   localparam logic [2:0] TRY_LIMIT   = 3'(MAX_TRIES);

   state_t     state_reg, state_next;
   logic       target_reg, target_next;
   logic [2:0] try_reg, try_next;
   logic [3:0] settle_reg, settle_next;
   logic       done_reg, done_next;
   logic       err_reg, err_next;
   // Goes high on the first edge after reset so req_ready stays low while in reset.
   logic       live_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= IDLE;
         target_reg <= 1'b0;
         try_reg    <= 3'd0;
         settle_reg <= 4'd0;
         done_reg   <= 1'b0;
         err_reg    <= 1'b0;
         live_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         target_reg <= target_next;
         try_reg    <= try_next;
         settle_reg <= settle_next;
         done_reg   <= done_next;
         err_reg    <= err_next;
         live_reg   <= 1'b1;
      end
   end

   always_comb begin
      state_next  = state_reg;
      target_next = target_reg;
      try_next    = try_reg;
      settle_next = settle_reg;
      done_next   = 1'b0;
      err_next    = err_reg;
      case (state_reg)
         IDLE: begin
            if (req_valid && live_reg) begin
               target_next = req_bit;
               try_next    = 3'd0;
               // An unknown q_fb falls through to the drive path.
               if (q_fb == req_bit) done_next = 1'b1;
               else                 state_next = DRIVE;
            end
         end
         DRIVE: begin
            try_next    = try_reg + 3'd1;
            settle_next = SETTLE_LOAD;
            state_next  = SETTLE;
         end
         SETTLE: begin
            if (settle_reg == 4'd0) state_next  = CHECK;
            else                    settle_next = settle_reg - 4'd1;
         end
         CHECK: begin
            if (q_fb == target_reg) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end else if (try_reg < TRY_LIMIT) begin
               state_next = DRIVE;
            end else begin
               state_next = IDLE;
               err_next   = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign req_ready = live_reg && (state_reg == IDLE);
   assign busy      = (state_reg != IDLE);
   assign s         = (state_reg == DRIVE) && target_reg;
   assign r         = (state_reg == DRIVE) && !target_reg;
   assign done      = done_reg;
   assign err       = err_reg;

endmodule

// File: doc/sr_driver.md
SR_DRIVER -- requirements
Module: sr_driver

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, number of wait cycles after an s/r pulse before q_fb is sampled (legal range 1..15).
REQ-002 Parameter MAX_TRIES, default 3, maximum pulses issued per request before an error is declared (legal range 1..7).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous reset, active-low (rst=0 resets).
REQ-005 req_valid  input  1  a target bit is offered.
REQ-006 req_bit  input  1  target value for the downstream SR flip-flop output.
REQ-007 req_ready  output  1  driver can accept a request this cycle.
REQ-008 q_fb  input  1  feedback of downstream flip-flop q.
REQ-009 s  output  1  set command to the downstream flip-flop.
REQ-010 r  output  1  reset command to the downstream flip-flop.
REQ-011 done  output  1  one-cycle pulse: request completed successfully.
REQ-012 err  output  1  sticky error flag: a request exhausted MAX_TRIES.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, SETTLE, CHECK.
REQ-015 req_ready SHALL equal 1 only in IDLE; a request is accepted on a clk edge with req_valid=1 and req_ready=1, latching req_bit as target.
REQ-016 On acceptance, if q_fb already equals req_bit, the FSM SHALL stay in IDLE and assert done on the next cycle with no s/r pulse (1-cycle latency).
REQ-017 On acceptance, if q_fb differs from req_bit (including X/Z on q_fb), the FSM SHALL move to DRIVE and clear the try counter to 0.
REQ-018 In DRIVE, for exactly one cycle, the block SHALL assert s=1,r=0 if target=1, or s=0,r=1 if target=0, increment the try counter, then go to SETTLE.
REQ-019 s and r SHALL never both be 1 in any cycle, and both SHALL be 0 in every state other than DRIVE.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles, counted by a down-counter, then go to CHECK.
REQ-021 In CHECK (one cycle), if q_fb equals target, the FSM SHALL go to IDLE and assert done for one cycle on the next cycle.
REQ-022 In CHECK, if q_fb differs from target and tries < MAX_TRIES, the FSM SHALL return to DRIVE and issue another pulse.
REQ-023 In CHECK, if q_fb differs from target and tries = MAX_TRIES, the FSM SHALL go to IDLE, set err=1, and not assert done.
REQ-024 err SHALL remain 1 until reset; subsequent requests SHALL still be accepted and processed normally.
REQ-025 req_valid/req_bit changes while busy=1 SHALL be ignored; the latched target SHALL not change mid-request.
REQ-026 Mismatch-path latency, success on first try: acceptance edge to done = 1 (DRIVE) + SETTLE_CYCLES + 1 (CHECK) + 1 cycles.
REQ-027 done and req_ready SHALL be allowed to be high in the same cycle, so back-to-back requests are accepted with no idle gap.

Reset
REQ-028 While rst=0, independent of clk: state=IDLE, s=0, r=0, done=0, err=0, busy=0, req_ready=0, try and settle counters=0.
REQ-029 On the first rising clk edge after rst deasserts, req_ready SHALL become 1.
REQ-030 A reset asserted mid-request (any state) SHALL abort the request immediately with no further s/r pulse and no done.

Verification
REQ-031 Match: q_fb=1, request req_bit=1 -> no s/r pulse, done=1 exactly 1 cycle after acceptance, err=0.
REQ-032 Set path, SETTLE_CYCLES=2: q_fb=0, request 1, model the flip-flop so q_fb follows s -> s=1 for exactly one cycle, done 5 cycles after acceptance.
REQ-033 Retry: q_fb ignores the first pulse and responds to the second -> two r pulses separated by SETTLE_CYCLES+1 cycles, then done, err=0.
REQ-034 Exhaustion, MAX_TRIES=3: q_fb stuck at 0, request 1 -> exactly 3 s pulses, no done, err=1 and held; next matching request still yields done.
REQ-035 Reset mid-SETTLE: rst=0 for 1 cycle -> s=r=0, busy=0, err=0 immediately; no done pulse afterwards.
REQ-036 Throughout every test: s&r never both 1; requests offered while busy=1 never change the pulse polarity.
